// File: rtl/wired_bpu_update_arb_pkg.sv
// Shared types and helpers for the branch-predictor update arbiter.
package wired_bpu_update_arb_pkg;

    // Default training-queue depth.
    localparam int WIRED_BPU_UPQ_DEPTH = 8;

    // One correction/training packet sent to the predictor.
    typedef struct packed {
        logic        redirect;       // redirect the front end to true_target
        logic        need_update;    // packet carries predictor training
        logic        miss;           // direction/target mispredict
        logic        ras_miss_type;  // mispredict that also restores RAS state
        logic [2:0]  ras_ptr;        // RAS pointer to restore
        logic [1:0]  tid;            // thread id
        logic        taken;          // resolved direction
        logic [31:0] pc;             // branch pc
        logic [31:0] true_target;    // resolved target
    } bpu_correct_t;

    // Strip the redirect-class flags from a training packet before queueing.
    function automatic bpu_correct_t wired_bpu_sanitise(input bpu_correct_t pkt);
        bpu_correct_t res;
        res               = pkt;
        res.redirect      = 1'b0;
        res.miss          = 1'b0;
        res.ras_miss_type = 1'b0;
        return res;
    endfunction

endpackage

// File: rtl/wired_bpu_upq_fifo.sv
// Two-write / one-read circular training queue. Lane 0 is written first.
module wired_bpu_upq_fifo
    import wired_bpu_update_arb_pkg::*;
#(
    parameter int DEPTH = WIRED_BPU_UPQ_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [1:0]                 push_en,
    input  bpu_correct_t [1:0]         push_data,
    input  logic                       pop,
    output bpu_correct_t               head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full2,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH+1);

    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [OCC_W-1:0] count_r;
    bpu_correct_t     mem_r [DEPTH];

    logic [OCC_W-1:0] n_push_s;
    logic             pop_ok_s;
    bpu_correct_t     first_data_s;

    // Push count, guarded pop and the packet landing in the first free slot.
    always_comb begin
        n_push_s = OCC_W'(push_en[0]) + OCC_W'(push_en[1]);
        pop_ok_s = pop && (count_r != '0);
        if (push_en[0]) begin
            first_data_s = push_data[0];
        end else begin
            first_data_s = push_data[1];
        end
    end

    // Storage write; slots need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_en[0] || push_en[1]) begin
            mem_r[wr_ptr_r] <= first_data_s;
        end
        if (push_en[0] && push_en[1]) begin
            mem_r[wr_ptr_r + PTR_W'(1)] <= push_data[1];
        end
    end

    // Pointer and fill-count update; reset discards all queued entries.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(n_push_s);
            rd_ptr_r <= rd_ptr_r + PTR_W'(pop_ok_s);
            count_r  <= count_r + n_push_s - OCC_W'(pop_ok_s);
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;
    assign empty = (count_r == '0);
    assign full2 = ((OCC_W'(DEPTH) - count_r) < OCC_W'(2));

endmodule

// File: rtl/wired_bpu_update_arb.sv
// Arbitrates redirects and buffered training updates onto the single,
// registered predictor correction port. Redirects always win.
module wired_bpu_update_arb
    import wired_bpu_update_arb_pkg::*;
#(
    parameter int DEPTH = WIRED_BPU_UPQ_DEPTH,
    parameter int CNT_W = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [1:0]                 cm_valid_i,
    input  bpu_correct_t [1:0]         cm_update_i,
    output logic                       cm_ready_o,
    input  logic                       rd_valid_i,
    input  bpu_correct_t               rd_update_i,
    output bpu_correct_t               p_correct_o,
    output logic [$clog2(DEPTH+1)-1:0] occupancy_o,
    output logic [CNT_W-1:0]           stall_cnt_o
);

    logic [1:0]         lane_en_s;
    bpu_correct_t [1:0] lane_data_s;
    logic               pop_s;
    logic               full2_s;
    logic               empty_s;
    bpu_correct_t       head_s;
    bpu_correct_t       p_next_s;
    logic [CNT_W-1:0]   stall_next_s;
    bpu_correct_t       p_correct_r;
    logic [CNT_W-1:0]   stall_cnt_r;

    // Ready comes from the registered fill only; no same-cycle pop credit.
    assign cm_ready_o = !full2_s;

    // Lane filter: accept trainable packets, drop no-op and illegal miss packets.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            lane_en_s[k]   = cm_valid_i[k] && cm_ready_o &&
                             cm_update_i[k].need_update &&
                             !cm_update_i[k].miss && !cm_update_i[k].ras_miss_type;
            lane_data_s[k] = wired_bpu_sanitise(cm_update_i[k]);
        end
    end

    wired_bpu_upq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_en   (lane_en_s),
        .push_data (lane_data_s),
        .pop       (pop_s),
        .head      (head_s),
        .count     (occupancy_o),
        .full2     (full2_s),
        .empty     (empty_s)
    );

    // Priority select: redirect, else queue head, else an idle all-zero packet.
    always_comb begin
        pop_s    = 1'b0;
        p_next_s = '0;
        if (rd_valid_i) begin
            p_next_s          = rd_update_i;
            p_next_s.redirect = 1'b1;
        end else if (!empty_s) begin
            p_next_s = head_s;
            pop_s    = 1'b1;
        end else begin
            p_next_s = '0;
        end
    end

    // Saturating count of cycles where a commit lane was held off.
    always_comb begin
        stall_next_s = stall_cnt_r;
        if ((|cm_valid_i) && !cm_ready_o && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_next_s = stall_cnt_r + CNT_W'(1);
        end else begin
            stall_next_s = stall_cnt_r;
        end
    end

    // Output register and stall counter state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p_correct_r <= '0;
            stall_cnt_r <= '0;
        end else begin
            p_correct_r <= p_next_s;
            stall_cnt_r <= stall_next_s;
        end
    end

    assign p_correct_o = p_correct_r;
    assign stall_cnt_o = stall_cnt_r;

endmodule

// File: tb/tb_wired_bpu_update_arb.sv
// Directed self-checking bench for wired_bpu_update_arb (DEPTH=8).
module tb_wired_bpu_update_arb;
    import wired_bpu_update_arb_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [1:0]         cm_valid;
    bpu_correct_t [1:0] cm_update;
    logic               cm_ready;
    logic               rd_valid;
    bpu_correct_t       rd_update;
    bpu_correct_t       p_correct;
    logic [3:0]         occupancy;
    logic [31:0]        stall_cnt;

    int errors = 0;
    int checks = 0;

    wired_bpu_update_arb #(.DEPTH(8), .CNT_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cm_valid_i  (cm_valid),
        .cm_update_i (cm_update),
        .cm_ready_o  (cm_ready),
        .rd_valid_i  (rd_valid),
        .rd_update_i (rd_update),
        .p_correct_o (p_correct),
        .occupancy_o (occupancy),
        .stall_cnt_o (stall_cnt)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bpu_correct_t mk(input logic [31:0] pc, input logic [31:0] tgt,
                                        input logic [1:0] tid, input logic nu);
        bpu_correct_t p;
        p = '0;
        p.pc = pc;
        p.true_target = tgt;
        p.tid = tid;
        p.need_update = nu;
        p.taken = 1'b1;
        return p;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; cm_valid = 2'b00; cm_update = '0; rd_valid = 1'b0; rd_update = '0;
        step(); step();
        rst_n = 1'b1;
        checks++; if (p_correct !== '0) begin errors++; $display("FAIL reset_pc: got %h want 0", p_correct); end
        checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
        checks++; if (cm_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", cm_ready); end
        checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_stall: got %0d want 0", stall_cnt); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (p_correct.redirect !== 1'b0 || p_correct.need_update !== 1'b0 || occupancy !== 4'd0 || cm_ready !== 1'b1) begin
                errors++; $display("FAIL idle_%0d: got pc=%h occ=%0d rdy=%b want zero/0/1", i, p_correct, occupancy, cm_ready);
            end
        end
    endtask

    task automatic test_redirect();
        bpu_correct_t exp;
        rd_valid = 1'b1; rd_update = mk(32'h1c00_0100 - 32'h4, 32'h1c00_0100, 2'd1, 1'b0);
        exp = rd_update; exp.redirect = 1'b1;
        step();
        rd_valid = 1'b0; rd_update = '0;
        checks++; if (p_correct !== exp) begin errors++; $display("FAIL redirect_pkt: got %h want %h", p_correct, exp); end
        checks++; if (p_correct.true_target !== 32'h1c00_0100 || p_correct.tid !== 2'd1) begin
            errors++; $display("FAIL redirect_fields: got tgt=%h tid=%0d want 1c000100/1", p_correct.true_target, p_correct.tid); end
        step();
        checks++; if (p_correct !== '0) begin errors++; $display("FAIL redirect_hold: got %h want 0", p_correct); end
    endtask

    task automatic test_dual_lane();
        bpu_correct_t e0, e1;
        e0 = mk(32'h1c00_0010, 32'h1c00_0800, 2'd0, 1'b1);
        e1 = mk(32'h1c00_0014, 32'h1c00_0900, 2'd0, 1'b1);
        cm_valid = 2'b11;
        cm_update[0] = e0; cm_update[0].redirect = 1'b1;   // must be stripped when queued
        cm_update[1] = e1;
        step();
        cm_valid = 2'b00;
        checks++; if (occupancy !== 4'd2) begin errors++; $display("FAIL dual_occ2: got %0d want 2", occupancy); end
        checks++; if (p_correct !== '0) begin errors++; $display("FAIL dual_nobypass: got %h want 0", p_correct); end
        step();
        checks++; if (p_correct !== e0) begin errors++; $display("FAIL dual_first: got %h want %h", p_correct, e0); end
        checks++; if (occupancy !== 4'd1) begin errors++; $display("FAIL dual_occ1: got %0d want 1", occupancy); end
        step();
        checks++; if (p_correct !== e1) begin errors++; $display("FAIL dual_second: got %h want %h", p_correct, e1); end
        checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL dual_occ0: got %0d want 0", occupancy); end
        step();
        checks++; if (p_correct !== '0) begin errors++; $display("FAIL dual_idle: got %h want 0", p_correct); end
    endtask

    task automatic test_filter();
        bpu_correct_t keep;
        cm_valid = 2'b11;
        cm_update[0] = mk(32'h1c00_0020, 32'h0, 2'd0, 1'b0);
        cm_update[1] = mk(32'h1c00_0024, 32'h0, 2'd0, 1'b1); cm_update[1].miss = 1'b1;
        step();
        checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL filter_drop: got %0d want 0", occupancy); end
        keep = mk(32'h1c00_0030, 32'h1c00_0a00, 2'd2, 1'b1);
        cm_update[0] = mk(32'h1c00_002c, 32'h0, 2'd0, 1'b1); cm_update[0].ras_miss_type = 1'b1;
        cm_update[1] = keep;
        step();
        cm_valid = 2'b00;
        checks++; if (occupancy !== 4'd1) begin errors++; $display("FAIL filter_keep_occ: got %0d want 1", occupancy); end
        step();
        checks++; if (p_correct !== keep) begin errors++; $display("FAIL filter_keep_pkt: got %h want %h", p_correct, keep); end
        step();
        checks++; if (p_correct !== '0 || occupancy !== 4'd0) begin
            errors++; $display("FAIL filter_idle: got %h occ=%0d want 0/0", p_correct, occupancy); end
    endtask

    task automatic test_fill();
        bpu_correct_t exp;
        logic [3:0]  occ_e;
        logic [31:0] stall_e;
        logic        rdy_e;
        // Redirects held high so nothing drains; the queue fills to DEPTH.
        for (int k = 0; k < 6; k++) begin
            cm_valid = 2'b11;
            cm_update[0] = mk(32'h1c00_1000 + 32'(8*k), 32'h1c00_4000, 2'd0, 1'b1);
            cm_update[1] = mk(32'h1c00_1004 + 32'(8*k), 32'h1c00_4000, 2'd0, 1'b1);
            rd_valid = 1'b1; rd_update = mk(32'h0, 32'h1c00_2000 + 32'(4*k), 2'd2, 1'b0);
            exp = rd_update; exp.redirect = 1'b1;
            occ_e   = (k >= 3) ? 4'd8 : 4'(2*(k+1));
            rdy_e   = (occ_e <= 4'd6);
            stall_e = (k >= 4) ? 32'(k-3) : 32'd0;
            step();
            checks++; if (occupancy !== occ_e) begin errors++; $display("FAIL fill_occ_%0d: got %0d want %0d", k, occupancy, occ_e); end
            checks++; if (cm_ready !== rdy_e) begin errors++; $display("FAIL fill_ready_%0d: got %b want %b", k, cm_ready, rdy_e); end
            checks++; if (stall_cnt !== stall_e) begin errors++; $display("FAIL fill_stall_%0d: got %0d want %0d", k, stall_cnt, stall_e); end
            checks++; if (p_correct !== exp) begin errors++; $display("FAIL fill_redir_%0d: got %h want %h", k, p_correct, exp); end
        end
        cm_valid = 2'b00; rd_valid = 1'b0; rd_update = '0;
        for (int i = 0; i < 8; i++) begin
            exp = mk(32'h1c00_1000 + 32'(4*i), 32'h1c00_4000, 2'd0, 1'b1);
            step();
            checks++; if (p_correct !== exp || occupancy !== 4'(7-i)) begin
                errors++; $display("FAIL drain_%0d: got %h occ=%0d want %h occ=%0d", i, p_correct, occupancy, exp, 7-i); end
        end
        step();
        checks++; if (p_correct !== '0) begin errors++; $display("FAIL drain_idle: got %h want 0", p_correct); end
    endtask

    task automatic test_back_to_back();
        bpu_correct_t a, b, c, r0, r1;
        a = mk(32'h1c00_3000, 32'h1c00_5000, 2'd0, 1'b1);
        b = mk(32'h1c00_3004, 32'h1c00_5004, 2'd1, 1'b1);
        c = mk(32'h1c00_3008, 32'h1c00_5008, 2'd2, 1'b1);
        r0 = mk(32'h0, 32'h1c00_6000, 2'd1, 1'b0); r0.miss = 1'b1;
        r1 = mk(32'h0, 32'h1c00_7000, 2'd3, 1'b0); r1.ras_miss_type = 1'b1; r1.ras_ptr = 3'd5;
        cm_valid = 2'b11; cm_update[0] = a; cm_update[1] = b;
        step();
        cm_valid = 2'b01; cm_update[0] = c; cm_update[1] = '0;
        rd_valid = 1'b1; rd_update = r0;
        step();
        cm_valid = 2'b00; rd_update = r1;
        checks++; if (occupancy !== 4'd3) begin errors++; $display("FAIL b2b_occ3: got %0d want 3", occupancy); end
        r0.redirect = 1'b1;
        checks++; if (p_correct !== r0) begin errors++; $display("FAIL b2b_r0: got %h want %h", p_correct, r0); end
        step();
        rd_valid = 1'b0; rd_update = '0;
        r1.redirect = 1'b1;
        checks++; if (p_correct !== r1 || occupancy !== 4'd3) begin
            errors++; $display("FAIL b2b_r1: got %h occ=%0d want %h occ=3", p_correct, occupancy, r1); end
        step();
        checks++; if (p_correct !== a) begin errors++; $display("FAIL b2b_a: got %h want %h", p_correct, a); end
        step();
        checks++; if (p_correct !== b) begin errors++; $display("FAIL b2b_b: got %h want %h", p_correct, b); end
        step();
        checks++; if (p_correct !== c || occupancy !== 4'd0) begin
            errors++; $display("FAIL b2b_c: got %h occ=%0d want %h occ=0", p_correct, occupancy, c); end
        step();
        checks++; if (p_correct !== '0) begin errors++; $display("FAIL b2b_idle: got %h want 0", p_correct); end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 3; k++) begin
            cm_valid = (k == 2) ? 2'b01 : 2'b11;
            cm_update[0] = mk(32'h1c00_8000 + 32'(8*k), 32'h1c00_9000, 2'd0, 1'b1);
            cm_update[1] = mk(32'h1c00_8004 + 32'(8*k), 32'h1c00_9000, 2'd0, 1'b1);
            rd_valid = 1'b1; rd_update = mk(32'h0, 32'h1c00_a000, 2'd0, 1'b0);
            step();
        end
        checks++; if (occupancy !== 4'd5) begin errors++; $display("FAIL rstmid_occ5: got %0d want 5", occupancy); end
        rst_n = 1'b0; cm_valid = 2'b00; rd_valid = 1'b0; rd_update = '0;
        step();
        rst_n = 1'b1;
        checks++; if (occupancy !== 4'd0 || p_correct !== '0 || cm_ready !== 1'b1 || stall_cnt !== 32'd0) begin
            errors++; $display("FAIL rstmid_state: got occ=%0d pc=%h rdy=%b stall=%0d want 0/0/1/0", occupancy, p_correct, cm_ready, stall_cnt); end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (p_correct !== '0 || occupancy !== 4'd0) begin
                errors++; $display("FAIL rstmid_stale_%0d: got %h occ=%0d want 0/0", i, p_correct, occupancy); end
        end
    endtask

    initial begin
        test_reset();
        test_redirect();
        test_dual_lane();
        test_filter();
        test_fill();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wired_bpu_update_arb.md
Name: wired_bpu_update_arb

Overview:
- Schedules all branch-resolution feedback onto the predictor's single correction port (one bpu_correct_t per cycle), sitting between the commit/redirect logic and wired_pcgen.
- Redirect packets (miss or RAS-type miss, which also restore RAS/tier state) take absolute priority.
- Non-miss training updates (direction counter, BTB target) from two commit lanes are buffered in a small queue and drained one per idle cycle.
- Output is registered, which cuts the backend-to-predictor timing path.

Parameters:
- DEPTH, 8, training-queue entries; power of two, >= 4.
- CNT_W, 32, width of the stall performance counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; one clock; reset is synchronous and active-low.
- cm_valid_i  in  2  per-lane commit update valid; lane 0 is older.
- cm_update_i  in  2 x bpu_correct_t  per-lane training packet.
- cm_ready_o  out  1  both lanes accepted this cycle (all-or-nothing).
- rd_valid_i  in  1  redirect request from backend.
- rd_update_i  in  bpu_correct_t  redirect packet: true_target, tid, miss, ras_miss_type, ras_ptr, training fields.
- p_correct_o  out  bpu_correct_t  registered correction packet to the predictor.
- occupancy_o  out  $clog2(DEPTH+1)  current queue fill.
- stall_cnt_o  out  CNT_W  saturating count of commit-stall cycles.

Behaviour:
- Reset (rst_n=0 at a clk edge): p_correct_o all-zero (redirect=0, need_update=0, miss=0), queue empty, occupancy_o=0, stall_cnt_o=0, cm_ready_o=1 in the first cycle after reset. Reset mid-operation discards all queued entries without emitting them.
- Enqueue filter, lane k: enqueue only if cm_valid_i[k] && cm_ready_o && cm_update_i[k].need_update.
  - Packets with need_update=0 are consumed and dropped.
  - Lane packets with miss=1 or ras_miss_type=1 are illegal. Bench asserts; RTL drops them.
  - Stored entries have redirect, miss and ras_miss_type forced to 0.
- Two valid lanes enqueue in order lane 0, then lane 1, in the same cycle.
- cm_ready_o = (DEPTH - occupancy) >= 2, computed from the registered count only, with no same-cycle pop credit.
- Output register, evaluated each cycle (next-state for p_correct_o):
  1. rd_valid_i=1: load rd_update_i with redirect=1; the queue is not popped this cycle.
  2. Else queue non-empty: load the head entry and pop it.
  3. Else: load all-zero.
- Latency:
  - Redirect: request in cycle N, visible on p_correct_o in N+1.
  - Training entry: enqueued in N, emitted no earlier than N+1 (bypass through empty queue allowed only via the register, never combinationally).
- p_correct_o holds each value for exactly one cycle; the predictor has no ready, so the port is never back-pressured.
- Simultaneous events:
  - Redirect + enqueue in the same cycle: both happen; occupancy +1/+2, no pop.
  - Enqueue + pop: occupancy += accepted - 1.
  - Back-to-back redirects starve the queue; draining resumes on the first cycle without a redirect. Order is strict FIFO, with no reordering or merging.
- Full: occupancy = DEPTH-1 or DEPTH gives cm_ready_o=0. Redirects are still accepted (they bypass the queue).
- Pointers: log2(DEPTH)-bit read/write pointers wrap modulo DEPTH. Occupancy never exceeds DEPTH (assert).
- Stall counter: stall_cnt_o increments when |cm_valid_i && !cm_ready_o, and saturates at all-ones.

Decomposition:
- Shared package/defines (alongside bpu_correct_t): WIRED_BPU_UPQ_DEPTH constant, and a helper function that sanitises a training packet (clears redirect/miss/ras_miss_type).
- Sub-module wired_bpu_upq_fifo: 2-write/1-read circular queue with ptrs, count, full2/empty flags. The arbiter top holds the priority mux, output register and stall counter.

Test Plan:
- Reset then idle: p_correct_o.redirect=0, need_update=0 every cycle; occupancy_o=0; cm_ready_o=1.
- Redirect only: rd_valid_i=1 with true_target=0x1c000100, tid=1 at cycle 5 -> p_correct_o.redirect=1, true_target=0x1c000100, tid=1 at cycle 6 only; cycle 7 all-zero.
- Dual-lane enqueue (pc 0x1c000010 lane 0, 0x1c000014 lane 1) -> emitted in cycles N+1 and N+2 in that order; miss=0, redirect=0; occupancy 2->1->0.
- Fill: DEPTH=8, 2 updates/cycle for 4 cycles with no redirect -> cm_ready_o drops after fill reaches 7 (or exactly 6 minus drained entries); stall_cnt_o counts each stalled valid cycle.
- Redirect collision: queue holds 3 entries, rd_valid_i for 2 consecutive cycles -> two redirect packets emitted first, then the 3 entries in FIFO order, with none lost.
- Reset mid-drain: rst_n=0 with 5 entries queued -> next cycle occupancy_o=0 and p_correct_o all-zero; no stale entry ever emitted afterwards.
